// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI flash controller request port between NCH masters.
// Captures request pulses, forwards the winner's cmd/len, routes its streams and optionally aborts hung transfers.
module spi_req_arbiter #(
    parameter int NCH   = 4,
    parameter int DSIZE = 8,
    parameter int CSIZE = 3,
    parameter int LSIZE = 24,
    parameter int TMO   = 0
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [NCH-1:0]         ch_request,
    input  logic [NCH*CSIZE-1:0]   ch_req_cmd,
    input  logic [NCH*LSIZE-1:0]   ch_req_len,
    input  logic [NCH*LSIZE-1:0]   ch_req_wr_len,
    output logic [NCH-1:0]         ch_busy,
    output logic [NCH-1:0]         ch_finish,
    output logic [NCH-1:0]         ch_error,
    input  logic [NCH-1:0]         ch_wr_vld,
    input  logic [NCH-1:0]         ch_wr_last,
    input  logic [NCH*DSIZE-1:0]   ch_wr_data,
    output logic [NCH-1:0]         ch_wr_ready,
    input  logic [NCH-1:0]         ch_rd_ready,
    output logic [NCH-1:0]         ch_rd_vld,
    output logic [NCH-1:0]         ch_rd_last,
    output logic [NCH*DSIZE-1:0]   ch_rd_data,
    output logic                   m_request,
    output logic [CSIZE-1:0]       m_req_cmd,
    output logic [LSIZE-1:0]       m_req_len,
    output logic [LSIZE-1:0]       m_req_wr_len,
    input  logic                   m_busy,
    input  logic                   m_finish,
    output logic                   m_wr_vld,
    output logic [DSIZE-1:0]       m_wr_data,
    output logic                   m_wr_last,
    input  logic                   m_wr_ready,
    output logic                   m_rd_ready,
    input  logic                   m_rd_vld,
    input  logic [DSIZE-1:0]       m_rd_data,
    input  logic                   m_rd_last,
    output logic [2:0]             dbg_state
);

    localparam int WW = $clog2(NCH);
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [WW-1:0]     winner, winner_nxt;
    logic [WW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [NCH-1:0]    pending, pending_nxt;
    logic [CSIZE-1:0]  lat_cmd, lat_cmd_nxt;
    logic [LSIZE-1:0]  lat_len, lat_len_nxt;
    logic [LSIZE-1:0]  lat_wr_len, lat_wr_len_nxt;
    logic [TW-1:0]     wdt, wdt_nxt;

    logic [NCH-1:0]    req_eff;
    logic [NCH-1:0]    cand;
    logic              sel_found;
    logic [WW-1:0]     sel_idx;
    logic [WW:0]       sel_sum;

    // m_busy is status only; sequencing relies solely on m_finish.
    logic unused_m_busy;
    assign unused_m_busy = m_busy;

    // Requests from a channel that is already pending or in service are dropped.
    always_comb begin
        req_eff   = ch_request & ~ch_busy;
        cand      = pending | req_eff;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_sum   = '0;
        for (int k = 0; k < NCH; k++) begin
            sel_sum = {1'b0, rr_ptr} + (WW+1)'(k);
            if (sel_sum >= (WW+1)'(NCH)) sel_sum = sel_sum - (WW+1)'(NCH);
            if (!sel_found && cand[sel_sum[WW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sel_sum[WW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        winner_nxt     = winner;
        rr_ptr_nxt     = rr_ptr;
        pending_nxt    = pending;
        lat_cmd_nxt    = lat_cmd;
        lat_len_nxt    = lat_len;
        lat_wr_len_nxt = lat_wr_len;
        wdt_nxt        = wdt;
        if (clk_en) begin
            pending_nxt = pending | req_eff;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        winner_nxt           = sel_idx;
                        lat_cmd_nxt          = ch_req_cmd[sel_idx*CSIZE +: CSIZE];
                        lat_len_nxt          = ch_req_len[sel_idx*LSIZE +: LSIZE];
                        lat_wr_len_nxt       = ch_req_wr_len[sel_idx*LSIZE +: LSIZE];
                        pending_nxt[sel_idx] = 1'b0;
                        state_nxt            = ISSUE;
                    end
                end
                ISSUE: begin
                    wdt_nxt   = '0;
                    state_nxt = RUN;
                end
                RUN: begin
                    if (wdt != TW'(TMO)) wdt_nxt = wdt + 1'b1;
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (m_finish)
                        state_nxt = DONE;
                    else if ((TMO > 0) && (wdt == TW'(TMO - 1)))
                        state_nxt = ABORT;
                end
                DONE, ABORT: begin
                    rr_ptr_nxt = (winner == WW'(NCH - 1)) ? '0 : winner + 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            winner     <= '0;
            rr_ptr     <= '0;
            pending    <= '0;
            lat_cmd    <= '0;
            lat_len    <= '0;
            lat_wr_len <= '0;
            wdt        <= '0;
        end else begin
            state      <= state_nxt;
            winner     <= winner_nxt;
            rr_ptr     <= rr_ptr_nxt;
            pending    <= pending_nxt;
            lat_cmd    <= lat_cmd_nxt;
            lat_len    <= lat_len_nxt;
            lat_wr_len <= lat_wr_len_nxt;
            wdt        <= wdt_nxt;
        end
    end

    // Streams use valid/ready: a beat transfers on a cycle where both are high; the
    // arbiter only wires the winner through during RUN and never stores data itself.
    always_comb begin
        ch_busy      = pending;
        ch_finish    = '0;
        ch_error     = '0;
        ch_wr_ready  = '0;
        ch_rd_vld    = '0;
        ch_rd_last   = '0;
        ch_rd_data   = '0;
        m_request    = (state == ISSUE);
        m_req_cmd    = '0;
        m_req_len    = '0;
        m_req_wr_len = '0;
        m_wr_vld     = 1'b0;
        m_wr_data    = '0;
        m_wr_last    = 1'b0;
        m_rd_ready   = 1'b0;
        dbg_state    = state;
        if (state != IDLE) begin
            ch_busy[winner] = 1'b1;
            m_req_cmd       = lat_cmd;
            m_req_len       = lat_len;
            m_req_wr_len    = lat_wr_len;
        end
        if (state == DONE || state == ABORT) ch_finish[winner] = 1'b1;
        if (state == ABORT) ch_error[winner] = 1'b1;
        if (state == RUN) begin
            m_wr_vld                          = ch_wr_vld[winner];
            m_wr_data                         = ch_wr_data[winner*DSIZE +: DSIZE];
            m_wr_last                         = ch_wr_last[winner];
            ch_wr_ready[winner]               = m_wr_ready;
            ch_rd_vld[winner]                 = m_rd_vld;
            ch_rd_last[winner]                = m_rd_last;
            ch_rd_data[winner*DSIZE +: DSIZE] = m_rd_data;
            m_rd_ready                        = ch_rd_ready[winner];
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: grant order, routing, watchdog abort, clock enable and reset.
module tb_spi_req_arbiter;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int CSIZE = 3;
    localparam int LSIZE = 24;
    localparam int TMO   = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;

    logic                 clock, rst_n, clk_en;
    logic [NCH-1:0]       ch_request;
    logic [NCH*CSIZE-1:0] ch_req_cmd;
    logic [NCH*LSIZE-1:0] ch_req_len, ch_req_wr_len;
    logic [NCH-1:0]       ch_busy, ch_finish, ch_error;
    logic [NCH-1:0]       ch_wr_vld, ch_wr_last, ch_wr_ready;
    logic [NCH*DSIZE-1:0] ch_wr_data;
    logic [NCH-1:0]       ch_rd_ready, ch_rd_vld, ch_rd_last;
    logic [NCH*DSIZE-1:0] ch_rd_data;
    logic                 m_request;
    logic [CSIZE-1:0]     m_req_cmd;
    logic [LSIZE-1:0]     m_req_len, m_req_wr_len;
    logic                 m_busy, m_finish;
    logic                 m_wr_vld, m_wr_last, m_wr_ready;
    logic [DSIZE-1:0]     m_wr_data;
    logic                 m_rd_ready, m_rd_vld, m_rd_last;
    logic [DSIZE-1:0]     m_rd_data;
    logic [2:0]           dbg_state;

    int checks = 0;
    int errors = 0;

    spi_req_arbiter #(.NCH(NCH), .DSIZE(DSIZE), .CSIZE(CSIZE), .LSIZE(LSIZE), .TMO(TMO)) dut (
        .clock(clock), .rst_n(rst_n), .clk_en(clk_en),
        .ch_request(ch_request), .ch_req_cmd(ch_req_cmd), .ch_req_len(ch_req_len),
        .ch_req_wr_len(ch_req_wr_len), .ch_busy(ch_busy), .ch_finish(ch_finish), .ch_error(ch_error),
        .ch_wr_vld(ch_wr_vld), .ch_wr_last(ch_wr_last), .ch_wr_data(ch_wr_data), .ch_wr_ready(ch_wr_ready),
        .ch_rd_ready(ch_rd_ready), .ch_rd_vld(ch_rd_vld), .ch_rd_last(ch_rd_last), .ch_rd_data(ch_rd_data),
        .m_request(m_request), .m_req_cmd(m_req_cmd), .m_req_len(m_req_len), .m_req_wr_len(m_req_wr_len),
        .m_busy(m_busy), .m_finish(m_finish),
        .m_wr_vld(m_wr_vld), .m_wr_data(m_wr_data), .m_wr_last(m_wr_last), .m_wr_ready(m_wr_ready),
        .m_rd_ready(m_rd_ready), .m_rd_vld(m_rd_vld), .m_rd_data(m_rd_data), .m_rd_last(m_rd_last),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t reached without finishing", $time);
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        ch_request = '0; ch_wr_vld = '0; ch_wr_last = '0; ch_wr_data = '0; ch_rd_ready = '0;
        m_busy = 1'b0; m_finish = 1'b0; m_wr_ready = 1'b0;
        m_rd_vld = 1'b0; m_rd_data = '0; m_rd_last = 1'b0;
    endtask

    task automatic set_cfg();
        for (int i = 0; i < NCH; i++) begin
            ch_req_cmd[i*CSIZE +: CSIZE]    = CSIZE'(i + 1);
            ch_req_len[i*LSIZE +: LSIZE]    = LSIZE'(16 * (i + 1));
            ch_req_wr_len[i*LSIZE +: LSIZE] = LSIZE'(i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk_en = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_issue(output int cyc);
        cyc = 0;
        while (m_request !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        clk_en = 1'b1;
        clear_inputs();
        set_cfg();
        ch_request = 4'hF;
        m_wr_ready = 1'b1;
        tick();
        checks++;
        if (ch_busy !== 4'h0 || m_request !== 1'b0 || dbg_state !== S_IDLE) begin
            $display("FAIL reset_state: busy=%b m_request=%b state=%0d required 0000/0/0", ch_busy, m_request, dbg_state);
            errors++;
        end
        checks++;
        if (m_req_cmd !== '0 || m_req_len !== '0 || ch_wr_ready !== '0 || ch_finish !== '0) begin
            $display("FAIL reset_outputs: cmd=%0d len=%0d wr_ready=%b finish=%b required all 0",
                     m_req_cmd, m_req_len, ch_wr_ready, ch_finish);
            errors++;
        end
        ch_request = '0;
        m_wr_ready = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_cfg();
        ch_req_cmd[2*CSIZE +: CSIZE]    = 3'd3;
        ch_req_len[2*LSIZE +: LSIZE]    = 24'd16;
        ch_req_wr_len[2*LSIZE +: LSIZE] = 24'd4;
        ch_request = 4'b0100;
        #1;
        checks++;
        if (m_request !== 1'b0) begin
            $display("FAIL single_no_early_req: m_request=%b required 0", m_request);
            errors++;
        end
        tick();
        ch_request = '0;
        #1;
        checks++;
        if (m_request !== 1'b1 || m_req_cmd !== 3'd3 || m_req_len !== 24'd16 || m_req_wr_len !== 24'd4) begin
            $display("FAIL single_issue: req=%b cmd=%0d len=%0d wr_len=%0d required 1/3/16/4",
                     m_request, m_req_cmd, m_req_len, m_req_wr_len);
            errors++;
        end
        checks++;
        if (ch_busy !== 4'b0100) begin
            $display("FAIL single_busy: ch_busy=%b required 0100", ch_busy);
            errors++;
        end
        tick();
        ch_request = 4'b0100;
        #1;
        checks++;
        if (m_request !== 1'b0 || m_req_cmd !== 3'd3 || dbg_state !== S_RUN) begin
            $display("FAIL single_run: req=%b cmd=%0d state=%0d required 0/3/2", m_request, m_req_cmd, dbg_state);
            errors++;
        end
        tick();
        ch_request = '0;
        m_finish = 1'b1;
        tick();
        m_finish = 1'b0;
        #1;
        checks++;
        if (ch_finish !== 4'b0100 || ch_error !== 4'b0000) begin
            $display("FAIL single_finish: finish=%b error=%b required 0100/0000", ch_finish, ch_error);
            errors++;
        end
        tick();
        checks++;
        if (ch_finish !== 4'b0000 || ch_busy !== 4'b0000 || m_req_cmd !== '0) begin
            $display("FAIL single_idle: finish=%b busy=%b cmd=%0d required 0000/0000/0", ch_finish, ch_busy, m_req_cmd);
            errors++;
        end
        m_finish = 1'b1;
        tick();
        m_finish = 1'b0;
        #1;
        checks++;
        if (m_request !== 1'b0 || ch_finish !== 4'b0000 || dbg_state !== S_IDLE) begin
            $display("FAIL single_stray_finish: req=%b finish=%b state=%0d required 0/0000/0",
                     m_request, ch_finish, dbg_state);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        int exp_ch;
        do_reset();
        set_cfg();
        ch_request = 4'hF;
        tick();
        ch_request = '0;
        for (int g = 0; g < 6; g++) begin
            exp_ch = (g < 4) ? g : g - 4;
            if (g == 4) begin
                ch_request = 4'b0011;
                tick();
                ch_request = '0;
            end
            wait_issue(cyc);
            checks++;
            if (m_request !== 1'b1 || m_req_cmd !== CSIZE'(exp_ch + 1)) begin
                $display("FAIL rr_grant%0d: m_request=%b cmd=%0d required 1/%0d", g, m_request, m_req_cmd, exp_ch + 1);
                errors++;
            end
            tick();
            m_finish = 1'b1;
            tick();
            m_finish = 1'b0;
            #1;
            checks++;
            if (ch_finish !== NCH'(1 << exp_ch)) begin
                $display("FAIL rr_finish%0d: ch_finish=%b required channel %0d", g, ch_finish, exp_ch);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic [5:0] pat;
        logic [7:0] exp_b;
        int idx;
        pat = 6'b110101;
        ch_wr_vld = 4'b0101;
        ch_wr_data = 32'h00550055;
        ch_request = 4'b0010;
        tick();
        ch_request = '0;
        m_wr_ready = 1'b1;
        #1;
        checks++;
        if (ch_wr_ready !== 4'b0000 || m_wr_vld !== 1'b0) begin
            $display("FAIL wr_issue_gated: wr_ready=%b m_wr_vld=%b required 0000/0", ch_wr_ready, m_wr_vld);
            errors++;
        end
        tick();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            exp_b = 8'hA1 + 8'(idx);
            ch_wr_vld[1] = 1'b1;
            ch_wr_data[1*DSIZE +: DSIZE] = exp_b;
            ch_wr_last[1] = (idx == 3);
            m_wr_ready = pat[c];
            #1;
            checks++;
            if (m_wr_vld !== 1'b1 || m_wr_data !== exp_b || m_wr_last !== (idx == 3)) begin
                $display("FAIL wr_beat%0d: vld=%b data=%h last=%b required 1/%h/%b", c, m_wr_vld, m_wr_data, m_wr_last,
                         exp_b, (idx == 3));
                errors++;
            end
            checks++;
            if (ch_wr_ready !== (pat[c] ? 4'b0010 : 4'b0000)) begin
                $display("FAIL wr_ready%0d: ch_wr_ready=%b required %b", c, ch_wr_ready, pat[c] ? 4'b0010 : 4'b0000);
                errors++;
            end
            if (pat[c]) idx++;
            tick();
        end
        ch_wr_vld[1] = 1'b0;
        ch_wr_last = '0;
        m_finish = 1'b1;
        m_wr_ready = 1'b1;
        tick();
        m_finish = 1'b0;
        #1;
        checks++;
        if (ch_finish !== 4'b0010 || ch_wr_ready !== 4'b0000 || m_wr_vld !== 1'b0) begin
            $display("FAIL wr_done: finish=%b wr_ready=%b m_wr_vld=%b required 0010/0000/0", ch_finish, ch_wr_ready, m_wr_vld);
            errors++;
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_read();
        logic [8:0] pat;
        logic [7:0] exp_b;
        int beat;
        pat = 9'b111111011;
        ch_request = 4'b1000;
        tick();
        ch_request = '0;
        tick();
        beat = 0;
        for (int c = 0; c < 9; c++) begin
            exp_b = 8'h30 + 8'(beat);
            m_rd_vld = 1'b1;
            m_rd_data = exp_b;
            m_rd_last = (beat == 7);
            ch_rd_ready = {pat[c], 3'b001};
            m_finish = (c == 8);
            #1;
            checks++;
            if (ch_rd_vld !== 4'b1000 || ch_rd_data !== {exp_b, 24'h0} || ch_rd_last !== ((beat == 7) ? 4'b1000 : 4'b0000)) begin
                $display("FAIL rd_beat%0d: vld=%b data=%h last=%b required 1000/%h000000/%b", c, ch_rd_vld, ch_rd_data,
                         ch_rd_last, exp_b, (beat == 7) ? 4'b1000 : 4'b0000);
                errors++;
            end
            checks++;
            if (m_rd_ready !== pat[c]) begin
                $display("FAIL rd_ready%0d: m_rd_ready=%b required %b", c, m_rd_ready, pat[c]);
                errors++;
            end
            if (pat[c]) beat++;
            tick();
        end
        m_finish = 1'b0;
        #1;
        checks++;
        if (ch_finish !== 4'b1000 || ch_rd_vld !== 4'b0000 || m_rd_ready !== 1'b0) begin
            $display("FAIL rd_done: finish=%b rd_vld=%b m_rd_ready=%b required 1000/0000/0", ch_finish, ch_rd_vld, m_rd_ready);
            errors++;
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_watchdog();
        int cyc;
        ch_request = 4'b0101;
        tick();
        ch_request = '0;
        #1;
        checks++;
        if (m_request !== 1'b1 || m_req_cmd !== 3'd1) begin
            $display("FAIL wdt_grant0: m_request=%b cmd=%0d required 1/1", m_request, m_req_cmd);
            errors++;
        end
        tick();
        for (int k = 0; k < TMO; k++) begin
            checks++;
            if (ch_finish !== 4'b0000 || dbg_state !== S_RUN) begin
                $display("FAIL wdt_early%0d: finish=%b state=%0d required 0000/2", k, ch_finish, dbg_state);
                errors++;
            end
            tick();
        end
        checks++;
        if (ch_finish !== 4'b0001 || ch_error !== 4'b0001) begin
            $display("FAIL wdt_abort: finish=%b error=%b required 0001/0001", ch_finish, ch_error);
            errors++;
        end
        tick();
        wait_issue(cyc);
        checks++;
        if (m_request !== 1'b1 || m_req_cmd !== 3'd3 || ch_busy !== 4'b0100) begin
            $display("FAIL wdt_next_grant: req=%b cmd=%0d busy=%b required 1/3/0100", m_request, m_req_cmd, ch_busy);
            errors++;
        end
        tick();
        m_finish = 1'b1;
        tick();
        m_finish = 1'b0;
        #1;
        checks++;
        if (ch_finish !== 4'b0100 || ch_error !== 4'b0000) begin
            $display("FAIL wdt_next_finish: finish=%b error=%b required 0100/0000", ch_finish, ch_error);
            errors++;
        end
        tick();
    endtask

    task automatic test_clk_en_reset();
        ch_request = 4'b0010;
        tick();
        ch_request = '0;
        tick();
        clk_en = 1'b0;
        m_finish = 1'b1;
        ch_request = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (dbg_state !== S_RUN || ch_finish !== 4'b0000 || ch_busy !== 4'b0010) begin
                $display("FAIL freeze%0d: state=%0d finish=%b busy=%b required 2/0000/0010", k, dbg_state, ch_finish, ch_busy);
                errors++;
            end
        end
        clk_en = 1'b1;
        m_finish = 1'b0;
        ch_request = '0;
        for (int k = 0; k < TMO - 1; k++) tick();
        checks++;
        if (dbg_state !== S_RUN || ch_finish !== 4'b0000) begin
            $display("FAIL freeze_wdt: state=%0d finish=%b required 2/0000", dbg_state, ch_finish);
            errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || ch_busy !== '0 || m_req_cmd !== '0 || m_req_len !== '0 || ch_finish !== '0) begin
            $display("FAIL run_reset: state=%0d busy=%b cmd=%0d len=%0d finish=%b required all 0",
                     dbg_state, ch_busy, m_req_cmd, m_req_len, ch_finish);
            errors++;
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ch_finish !== 4'b0000 || ch_busy !== 4'b0000 || dbg_state !== S_IDLE) begin
                $display("FAIL post_reset%0d: finish=%b busy=%b state=%0d required 0000/0000/0", k, ch_finish, ch_busy, dbg_state);
                errors++;
            end
        end
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_streaming();
        test_read();
        test_watchdog();
        test_clk_en_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
